// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receive front end: oversamples the serial pin, recovers bytes and
// writes them into the receive ring buffer, flagging framing errors and overruns.
module uart_rx_deserializer #(
   parameter int CLKS_PER_BIT = 187,
   parameter int DEPTH        = 32,
   parameter bit DATA_INVERT  = 1'b1
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        uart_port_DI,
   input  logic [15:0] read_ptr,
   output logic        wr_en,
   output logic [15:0] wr_ptr,
   output logic [7:0]  rx_DO,
   output logic        frame_err,
   output logic        overrun,
   output logic        rx_busy
);
   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [15:0]      PTR_LAST = 16'(DEPTH - 1);
   localparam logic [7:0]       INV_MASK = DATA_INVERT ? 8'hFF : 8'h00;

   typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic             sync1_q, rx_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       rx_do_q, rx_do_d;
   logic [15:0]      wr_ptr_q, wr_ptr_d, ptr_next;
   logic             wr_en_q, wr_en_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             busy_q;
   logic             full;

   // Full is evaluated on the live read_ptr so a same-cycle consumer advance counts.
   assign ptr_next = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 16'd1;
   assign full     = (ptr_next == read_ptr);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      rx_do_d     = rx_do_q;
      wr_en_d     = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      wr_ptr_d    = wr_en_q ? ptr_next : wr_ptr_q;
      case (state_q)
         WAIT_HIGH: begin
            if (!rx_s_q) begin
               cnt_d = '0;
            end else if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == LAST) begin
               cnt_d     = '0;
               shreg_d   = {rx_s_q, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_HIGH;
               end else if (full) begin
                  overrun_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  wr_en_d = 1'b1;
                  rx_do_d = shreg_q ^ INV_MASK;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = WAIT_HIGH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= WAIT_HIGH;
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         rx_do_q     <= '0;
         wr_ptr_q    <= '0;
         wr_en_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= uart_port_DI;
         rx_s_q      <= sync1_q;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         rx_do_q     <= rx_do_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_en_q     <= wr_en_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= (state_q == START) || (state_q == DATA) || (state_q == STOP);
      end
   end

   // Pulses are masked while clear is high so none leak out during a reset cycle.
   assign wr_en     = wr_en_q & ~clear;
   assign frame_err = frame_err_q & ~clear;
   assign overrun   = overrun_q & ~clear;
   assign wr_ptr    = wr_ptr_q;
   assign rx_DO     = rx_do_q;
   assign rx_busy   = busy_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: frames are serialised from bytes,
// and a queue of expected outcomes (write/overrun/frame error) is checked every cycle.
module tb_uart_rx_deserializer;
   localparam int CPB   = 187;
   localparam int DEPTH = 32;
   localparam bit INV   = 1'b1;
   localparam int LAT   = 1778;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic        pin = 1'b1;
   logic [15:0] read_ptr = '0;
   logic        wr_en, frame_err, overrun, rx_busy;
   logic [15:0] wr_ptr;
   logic [7:0]  rx_DO;

   uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .DATA_INVERT(INV)) dut (
      .clk(clk), .clear(clear), .uart_port_DI(pin), .read_ptr(read_ptr),
      .wr_en(wr_en), .wr_ptr(wr_ptr), .rx_DO(rx_DO), .frame_err(frame_err),
      .overrun(overrun), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind is {wr_en, frame_err, overrun}
   typedef struct {
      logic [2:0] kind;
      logic [7:0] data;
      int         slot;
      int         start;
   } ev_t;

   ev_t        exp_q[$];
   int         n_checks = 0;
   int         n_errs = 0;
   int         m_ptr = 0;
   int         pred_ptr = 0;
   logic [7:0] m_rxdo = '0;
   bit         chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic cmp_cycle();
      logic [2:0] p;
      ev_t        ev;
      int         lat;
      p = {wr_en, frame_err, overrun};
      if (clear) check("pulse_during_clear", p, 3'b000);
      if (p != 3'b000) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", p, 3'b000);
         end else begin
            ev = exp_q.pop_front();
            check("pulse_kind", p, ev.kind);
            lat = cyc - ev.start - 1;
            n_checks++;
            if (lat < LAT - 2 || lat > LAT + 2) begin
               n_errs++;
               $display("FAIL latency: got %0d cycles, want %0d+-2", lat, LAT);
            end
            if (wr_en) begin
               check("wr_slot", wr_ptr, ev.slot);
               m_rxdo = ev.data;
            end
         end
      end
      check("rx_DO", rx_DO, m_rxdo);
      check("wr_ptr", wr_ptr, m_ptr);
      if (wr_en) m_ptr = (m_ptr + 1) % DEPTH;
      if (clear) begin
         m_ptr  = 0;
         m_rxdo = '0;
         exp_q.delete();
      end
   endtask

   task automatic bits(input logic v, input int n);
      pin = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_frame(input logic [7:0] b, input bit stop_ok);
      ev_t ev;
      ev.data  = b;
      ev.slot  = pred_ptr;
      ev.start = cyc;
      if (!stop_ok) ev.kind = 3'b010;
      else if ((pred_ptr + 1) % DEPTH == int'(read_ptr)) ev.kind = 3'b001;
      else begin
         ev.kind  = 3'b100;
         pred_ptr = (pred_ptr + 1) % DEPTH;
      end
      exp_q.push_back(ev);
   endtask

   task automatic send(input logic [7:0] b, input bit stop_ok, input int blen);
      expect_frame(b, stop_ok);
      bits(1'b0, blen);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            bits(b[i] ^ INV, blen / 2);
            check("rx_busy_mid_frame", rx_busy, 1'b1);
            bits(b[i] ^ INV, blen - blen / 2);
         end else begin
            bits(b[i] ^ INV, blen);
         end
      end
      bits(stop_ok, blen);
   endtask

   task automatic do_reset();
      clear = 1'b1;
      bits(1'b1, 3);
      clear    = 1'b0;
      pred_ptr = 0;
      bits(1'b1, 200);
   endtask

   task automatic check_idle_reset(input string tag);
      check({tag, "_wr_en"}, wr_en, 1'b0);
      check({tag, "_wr_ptr"}, wr_ptr, 16'd0);
      check({tag, "_rx_DO"}, rx_DO, 8'h00);
      check({tag, "_frame_err"}, frame_err, 1'b0);
      check({tag, "_overrun"}, overrun, 1'b0);
      check({tag, "_rx_busy"}, rx_busy, 1'b0);
   endtask

   initial begin
      logic [7:0] rb;
      int         gap, blen;
      fork
         forever begin
            @(negedge clk);
            if (chk_en) cmp_cycle();
         end
      join_none

      @(posedge clk);
      #1;
      bits(1'b1, 4);
      check_idle_reset("reset");
      chk_en = 1'b1;
      clear  = 1'b0;
      bits(1'b1, 200);

      // Single inverted-data frame 'A'
      send(8'h41, 1'b1, CPB);
      check("t1_rx_DO", rx_DO, 8'h41);
      check("t1_wr_ptr", wr_ptr, 16'd1);
      bits(1'b1, 50);

      // Back-to-back A, B, C
      do_reset();
      send(8'h41, 1'b1, CPB);
      send(8'h42, 1'b1, CPB);
      send(8'h43, 1'b1, CPB);
      check("t2_rx_DO", rx_DO, 8'h43);
      check("t2_wr_ptr", wr_ptr, 16'd3);

      // Start-bit glitch, then a valid 0x55
      bits(1'b0, 40);
      bits(1'b1, 300);
      check("t3_glitch_wr_ptr", wr_ptr, 16'd3);
      send(8'h55, 1'b1, CPB);
      check("t3_rx_DO", rx_DO, 8'h55);

      // Framing error, minimum recovery idle, then 0x5A
      send(8'hC3, 1'b0, CPB);
      check("t4_ferr_wr_ptr", wr_ptr, 16'd4);
      bits(1'b1, CPB);
      send(8'h5A, 1'b1, CPB);
      check("t4_rx_DO", rx_DO, 8'h5A);
      check("t4_wr_ptr", wr_ptr, 16'd5);

      // Fill the ring with random frames (random gaps and slight baud mismatch)
      do_reset();
      read_ptr = 16'd0;
      for (int i = 0; i < 31; i++) begin
         rb   = 8'($urandom);
         gap  = int'($urandom_range(0, 20));
         blen = CPB - 3 + int'($urandom_range(0, 6));
         bits(1'b1, gap);
         send(rb, 1'b1, blen);
      end
      check("t5_full_wr_ptr", wr_ptr, 16'd31);
      send(8'hA5, 1'b1, CPB);
      check("t5_overrun_wr_ptr", wr_ptr, 16'd31);
      read_ptr = 16'd1;
      send(8'h3C, 1'b1, CPB);
      check("t5_wrap_wr_ptr", wr_ptr, 16'd0);
      check("t5_wrap_rx_DO", rx_DO, 8'h3C);

      // Clear at mid data bit 4 abandons the frame
      read_ptr = 16'd0;
      send(8'h11, 1'b1, CPB);
      check("t6_pre_wr_ptr", wr_ptr, 16'd1);
      rb = 8'hE7;
      bits(1'b0, CPB);
      for (int i = 0; i < 4; i++) bits(rb[i] ^ INV, CPB);
      bits(rb[4] ^ INV, CPB / 2);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      pred_ptr = 0;
      pin      = 1'b1;
      check_idle_reset("t6_clear");
      bits(1'b1, CPB);
      send(8'h96, 1'b1, CPB);
      check("t6_rx_DO", rx_DO, 8'h96);
      check("t6_wr_ptr", wr_ptr, 16'd1);

      bits(1'b1, 2200);
      check("pending_events", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
